// File: rtl/ulpi_rx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_rx_packetizer
// Brief    : Frames ULPI receive bytes into tagged USB packets (first/last/err)
//            and buffers them in a FIFO behind a valid/ready output stream.
//            Optional macro ULPI_RX_PID_CHECK_EN flags a bad PID complement.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_rx_packetizer #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       sys_data,
   input  logic             sys_data_valid,
   input  logic [7:0]       sys_rx_cmd,
   output logic [7:0]       out_data,
   output logic             out_first,
   output logic             out_last,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FLUSH  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rx_active_q;
   logic [7:0]       hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic             first_pend_q, first_pend_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]    out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [EW-1:0]    mem [FIFO_DEPTH];

   logic             rx_active;
   logic             rx_error;
   logic             pid_bad;
   logic             fifo_full;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic             drop_inc;
   logic [EW-1:0]    push_data;
   logic             unused_cmd_bits;

   assign rx_active       = sys_rx_cmd[4];
   assign rx_error        = (sys_rx_cmd[5:4] == 2'b11);
   assign unused_cmd_bits = ^{sys_rx_cmd[7:6], sys_rx_cmd[3:0]};

`ifdef ULPI_RX_PID_CHECK_EN
   assign pid_bad = (sys_data[7:4] != ~sys_data[3:0]);
`else
   assign pid_bad = 1'b0;
`endif

   // Full is taken from the registered pointers, so a same-cycle pop never frees room
   assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = out_valid_q & out_ready;
   assign push_ok   = push_req & ~fifo_full;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      first_pend_d = first_pend_q;
      err_sticky_d = err_sticky_q;
      push_req     = 1'b0;
      push_data    = '0;
      drop_inc     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sys_data_valid) begin
               drop_inc = 1'b1;
            end
            if (rx_active && !rx_active_q) begin
               state_d      = S_ACTIVE;
               err_sticky_d = 1'b0;
               first_pend_d = 1'b1;
            end
         end

         S_ACTIVE: begin
            if (rx_error) begin
               err_sticky_d = 1'b1;
            end
            if (sys_data_valid) begin
               if (hold_valid_q) begin
                  push_req  = 1'b1;
                  push_data = {first_pend_q, 1'b0, 1'b0, hold_q};
                  if (fifo_full) begin
                     err_sticky_d = 1'b1;
                     drop_inc     = 1'b1;
                  end else begin
                     first_pend_d = 1'b0;
                  end
               end else if (pid_bad) begin
                  err_sticky_d = 1'b1;
               end
               hold_d       = sys_data;
               hold_valid_d = 1'b1;
            end
            // A byte arriving with the falling edge is held and flushed as last
            if (!rx_active) begin
               state_d = hold_valid_d ? S_FLUSH : S_IDLE;
            end
         end

         S_FLUSH: begin
            if (sys_data_valid) begin
               drop_inc = 1'b1;
            end
            push_req  = 1'b1;
            push_data = {first_pend_q, 1'b1, err_sticky_q, hold_q};
            if (!fifo_full) begin
               hold_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

      if (drop_inc && !(&drop_cnt_q)) begin
         drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         drop_cnt_d = drop_cnt_q;
      end

      // Output register tracks the next head; bypass when the head is being written now
      out_valid_d = (wr_ptr_d != rd_ptr_d);
      if (!out_valid_d) begin
         out_d = '0;
      end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
         out_d = push_data;
      end else begin
         out_d = mem[rd_ptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rx_active_q  <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         first_pend_q <= 1'b0;
         err_sticky_q <= 1'b0;
         drop_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_active_q  <= rx_active;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         first_pend_q <= first_pend_d;
         err_sticky_q <= err_sticky_d;
         drop_cnt_q   <= drop_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_first = out_q[10];
   assign out_last  = out_q[9];
   assign out_err   = out_q[8];
   assign out_data  = out_q[7:0];
   assign out_valid = out_valid_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire
